rez_to_bcd: RTL and testbench



---
 rtl/rez_to_bcd_pkg.sv | 14 +
 rtl/rez_to_bcd_bcd_add3.sv | 15 +
 rtl/rez_to_bcd.sv | 94 +++++++++
 tb/tb_rez_to_bcd.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rez_to_bcd_pkg.sv
// Shared definitions for the two's-complement to BCD converter.
package rez_to_bcd_pkg;

  localparam int unsigned WIDTH_DEF  = 9;
  localparam int unsigned DIGITS_DEF = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_OFFSET = 4'd3;

endpackage

// File: rtl/rez_to_bcd_bcd_add3.sv
// Double-dabble digit corrector: digits of 5 or more get +3 before the shift.
module bcd_add3
  import rez_to_bcd_pkg::*;
(
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  always_comb begin
    d_out = d_in;
    if (d_in >= ADD3_THRESH)
      d_out = d_in + ADD3_OFFSET;
  end

endmodule

// File: rtl/rez_to_bcd.sv
// Sequential sign/magnitude BCD converter for the add/subtract stage result,
// one double-dabble step per clock with a start/busy/done handshake.
module rez_to_bcd
  import rez_to_bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                  Clk_in,
  input  logic                  Rst_in,
  input  logic                  Start_in,
  input  logic [WIDTH-1:0]      Rez_in,
  output logic                  Busy_out,
  output logic                  Done_out,
  output logic                  Sign_out,
  output logic [4*DIGITS-1:0]   Bcd_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             sign_r;
  logic [WIDTH-1:0] mag;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_corr;
  logic [BCD_W-1:0] bcd_next;
  logic [WIDTH-1:0] mag_next;
  logic             accept;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .d_in  (bcd[4*g +: 4]),
      .d_out (bcd_corr[4*g +: 4])
    );
  end

  // Correct all digits first, then shift {bcd, mag} left by one.
  always_comb begin
    bcd_next = {bcd_corr[BCD_W-2:0], mag[WIDTH-1]};
    mag_next = {mag[WIDTH-2:0], 1'b0};
  end

  assign accept = Start_in && ((state == IDLE) || (state == DONE));

  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      state    <= IDLE;
      cnt      <= '0;
      sign_r   <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      Busy_out <= 1'b0;
      Done_out <= 1'b0;
      Sign_out <= 1'b0;
      Bcd_out  <= '0;
    end else begin
      Done_out <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            sign_r   <= Rez_in[WIDTH-1];
            mag      <= Rez_in[WIDTH-1] ? (~Rez_in + 1'b1) : Rez_in;
            bcd      <= '0;
            cnt      <= '0;
            Busy_out <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          bcd <= bcd_next;
          mag <= mag_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            Bcd_out  <= bcd_next;
            Sign_out <= sign_r;
            Done_out <= 1'b1;
            Busy_out <= 1'b0;
            state    <= DONE;
          end
        end
        default: begin
          state    <= IDLE;
          Busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rez_to_bcd.sv
// Directed self-checking bench for rez_to_bcd.
module tb_rez_to_bcd;

  logic        Clk_in;
  logic        Rst_in;
  logic        Start_in;
  logic [8:0]  Rez_in;
  logic        Busy_out;
  logic        Done_out;
  logic        Sign_out;
  logic [11:0] Bcd_out;

  int unsigned n_checks;
  int unsigned n_fail;

  rez_to_bcd #(.WIDTH(9), .DIGITS(3)) dut (
    .Clk_in   (Clk_in),
    .Rst_in   (Rst_in),
    .Start_in (Start_in),
    .Rez_in   (Rez_in),
    .Busy_out (Busy_out),
    .Done_out (Done_out),
    .Sign_out (Sign_out),
    .Bcd_out  (Bcd_out)
  );

  initial Clk_in = 1'b0;
  always #5 Clk_in = ~Clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits (at negedges) for Done_out; returns the number of negedges waited
  // and how many of them had Busy_out high.
  task automatic wait_done(output int unsigned lat, output int unsigned busy_n);
    lat = 0;
    busy_n = 0;
    while (!Done_out && lat < 30) begin
      if (Busy_out) busy_n++;
      @(negedge Clk_in);
      lat++;
    end
  endtask

  task automatic run_conv(input string tag, input logic [8:0] v,
                          input logic [11:0] exp_bcd, input logic exp_sign);
    int unsigned lat, busy_n;
    @(negedge Clk_in);
    Rez_in = v;
    Start_in = 1'b1;
    @(negedge Clk_in);
    Start_in = 1'b0;
    wait_done(lat, busy_n);
    check({tag, "_lat"}, lat, 9);
    check({tag, "_busy"}, busy_n, 9);
    check({tag, "_done"}, Done_out, 1'b1);
    check({tag, "_bcd"}, Bcd_out, exp_bcd);
    check({tag, "_sign"}, Sign_out, exp_sign);
    check({tag, "_busy_at_done"}, Busy_out, 1'b0);
    @(negedge Clk_in);
    check({tag, "_done_pulse"}, Done_out, 1'b0);
  endtask

  initial begin
    int unsigned lat, busy_n, pulses;
    n_checks = 0;
    n_fail = 0;
    Rst_in = 1'b1;
    Start_in = 1'b0;
    Rez_in = '0;
    repeat (2) @(negedge Clk_in);
    check("rst_busy", Busy_out, 1'b0);
    check("rst_done", Done_out, 1'b0);
    check("rst_sign", Sign_out, 1'b0);
    check("rst_bcd", Bcd_out, 12'h000);
    Rst_in = 1'b0;

    run_conv("pos_max", 9'h0FF, 12'h255, 1'b1 & 1'b0);
    run_conv("neg_min", 9'h100, 12'h256, 1'b1);
    run_conv("neg_7", 9'h1F9, 12'h007, 1'b1);
    run_conv("zero", 9'h000, 12'h000, 1'b0);

    // Start and input change mid-conversion must be ignored.
    @(negedge Clk_in);
    Rez_in = 9'h07B;
    Start_in = 1'b1;
    @(negedge Clk_in);
    Start_in = 1'b0;
    repeat (2) @(negedge Clk_in);
    Rez_in = 9'h1FF;
    Start_in = 1'b1;
    @(negedge Clk_in);
    Start_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (Done_out) begin
        pulses++;
        check("intf_bcd", Bcd_out, 12'h123);
        check("intf_sign", Sign_out, 1'b0);
      end
      @(negedge Clk_in);
    end
    check("intf_pulses", pulses, 1);
    check("intf_busy_idle", Busy_out, 1'b0);

    // Back-to-back with Start_in held high.
    Rez_in = 9'h02A;
    Start_in = 1'b1;
    @(negedge Clk_in);
    wait_done(lat, busy_n);
    check("b2b1_lat", lat, 9);
    check("b2b1_bcd", Bcd_out, 12'h042);
    check("b2b1_sign", Sign_out, 1'b0);
    Rez_in = 9'h1D6;
    @(negedge Clk_in);
    check("b2b_busy_again", Busy_out, 1'b1);
    wait_done(lat, busy_n);
    check("b2b_gap", lat + 1, 10);
    check("b2b2_bcd", Bcd_out, 12'h042);
    check("b2b2_sign", Sign_out, 1'b1);
    Start_in = 1'b0;
    repeat (2) @(negedge Clk_in);

    // Abort during the 4th shift cycle.
    Rez_in = 9'h0FF;
    Start_in = 1'b1;
    @(negedge Clk_in);
    Start_in = 1'b0;
    repeat (3) @(negedge Clk_in);
    Rst_in = 1'b1;
    @(negedge Clk_in);
    Rst_in = 1'b0;
    check("abort_busy", Busy_out, 1'b0);
    check("abort_bcd", Bcd_out, 12'h000);
    check("abort_sign", Sign_out, 1'b0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (Done_out) pulses++;
      @(negedge Clk_in);
    end
    check("abort_no_done", pulses, 0);
    check("abort_bcd_hold", Bcd_out, 12'h000);
    run_conv("after_abort", 9'h064, 12'h100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
